// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-enable strobe from the system clock, pixel/line
// counters, and registered sync/blank/active-video decodes aligned with the counts.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hs,
    output logic        vs,
    output logic        hblank,
    output logic        vblank,
    output logic        video_on,
    output logic        frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [10:0]      h_next;
    logic [10:0]      v_next;

    assign pix_en      = (div == DIV_LAST);
    assign frame_start = pix_en && (hcount == '0) && (vcount == '0);

    always_comb begin
        h_next = hcount;
        v_next = vcount;
        if (hcount == 11'(H_TOTAL - 1)) begin
            h_next = '0;
            if (vcount == 11'(V_TOTAL - 1))
                v_next = '0;
            else
                v_next = vcount + 11'd1;
        end else begin
            h_next = hcount + 11'd1;
        end
    end

    // Decodes are taken from the next-state counts so they switch on the same
    // edge as hcount/vcount, with no pipeline skew.
    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            hcount   <= '0;
            vcount   <= '0;
            hs       <= ~HS_POL;
            vs       <= ~VS_POL;
            hblank   <= 1'b0;
            vblank   <= 1'b0;
            video_on <= 1'b1;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            if (pix_en) begin
                hcount   <= h_next;
                vcount   <= v_next;
                hs       <= (h_next >= 11'(HS_START) && h_next <= 11'(HS_END)) ? HS_POL : ~HS_POL;
                vs       <= (v_next >= 11'(VS_START) && v_next <= 11'(VS_END)) ? VS_POL : ~VS_POL;
                hblank   <= (h_next >= 11'(H_VISIBLE));
                vblank   <= (v_next >= 11'(V_VISIBLE));
                video_on <= (h_next < 11'(H_VISIBLE)) && (v_next < 11'(V_VISIBLE));
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing, reduced-timing and inverted-polarity
// instances checked against a closed-form raster model plus scenario tasks.
module tb_vga_sync_gen;

    typedef struct {
        int d, hv, hfp, hsw, hbp, vv, vfp, vsw, vbp;
        bit hp, vp;
    } cfg_t;

    typedef struct packed {
        logic        pix_en;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs, vs, hb, vb, von, fs;
    } exp_t;

    typedef exp_t [2:0] trio_t;

    logic        clk = 1'b0;
    logic [2:0]  rst = 3'b111;
    logic        pe [3];
    logic [10:0] hc [3];
    logic [10:0] vc [3];
    logic        hsy [3], vsy [3], hb [3], vb [3], von [3], fs [3];

    int    tests_run = 0;
    int    fails = 0;
    int    k [3];
    trio_t sb [$];

    always #10 clk = ~clk;

    vga_sync_gen dut0 (
        .clk(clk), .rst(rst[0]), .pix_en(pe[0]), .hcount(hc[0]), .vcount(vc[0]),
        .hs(hsy[0]), .vs(vsy[0]), .hblank(hb[0]), .vblank(vb[0]), .video_on(von[0]),
        .frame_start(fs[0])
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut1 (
        .clk(clk), .rst(rst[1]), .pix_en(pe[1]), .hcount(hc[1]), .vcount(vc[1]),
        .hs(hsy[1]), .vs(vsy[1]), .hblank(hb[1]), .vblank(vb[1]), .video_on(von[1]),
        .frame_start(fs[1])
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut2 (
        .clk(clk), .rst(rst[2]), .pix_en(pe[2]), .hcount(hc[2]), .vcount(vc[2]),
        .hs(hsy[2]), .vs(vsy[2]), .hblank(hb[2]), .vblank(vb[2]), .video_on(von[2]),
        .frame_start(fs[2])
    );

    function automatic cfg_t cfg_of(int i);
        cfg_t c;
        c = '{d: 2, hv: 640, hfp: 16, hsw: 96, hbp: 48, vv: 480, vfp: 10, vsw: 2, vbp: 33,
              hp: 1'b0, vp: 1'b0};
        if (i != 0) begin
            c.hv = 16; c.hfp = 4; c.hsw = 6; c.hbp = 4;
            c.vv = 12; c.vfp = 2; c.vsw = 2; c.vbp = 3;
        end
        if (i == 2) begin
            c.d = 1; c.hp = 1'b1; c.vp = 1'b1;
        end
        return c;
    endfunction

    // k = clocks since the last reset edge; pixel index is k / CLK_DIV.
    function automatic exp_t model(cfg_t c, int kk);
        exp_t e;
        int ht, vt, p, h, v;
        ht = c.hv + c.hfp + c.hsw + c.hbp;
        vt = c.vv + c.vfp + c.vsw + c.vbp;
        p  = kk / c.d;
        h  = p % ht;
        v  = (p / ht) % vt;
        e.pix_en = ((kk % c.d) == c.d - 1);
        e.h   = 11'(h);
        e.v   = 11'(v);
        e.hs  = (h >= c.hv + c.hfp && h < c.hv + c.hfp + c.hsw) ? c.hp : !c.hp;
        e.vs  = (v >= c.vv + c.vfp && v < c.vv + c.vfp + c.vsw) ? c.vp : !c.vp;
        e.hb  = (h >= c.hv);
        e.vb  = (v >= c.vv);
        e.von = !e.hb && !e.vb;
        e.fs  = e.pix_en && h == 0 && v == 0;
        return e;
    endfunction

    always @(posedge clk) begin
        trio_t t;
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) k[i] = 0;
            else        k[i] = k[i] + 1;
            t[i] = model(cfg_of(i), k[i]);
        end
        sb.push_back(t);
    end

    always @(negedge clk) begin
        trio_t t;
        exp_t  a;
        if (sb.size() > 0) begin
            t = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                a = '{pix_en: pe[i], h: hc[i], v: vc[i], hs: hsy[i], vs: vsy[i],
                      hb: hb[i], vb: vb[i], von: von[i], fs: fs[i]};
                tests_run++;
                if (a !== t[i]) begin
                    fails++;
                    $display("FAIL sb_dut%0d t=%0t actual=%h expected=%h", i, $time, a, t[i]);
                end
            end
        end
    end

    task automatic test_reset;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if ({pe[0], hc[0], vc[0], hsy[0], vsy[0], hb[0], vb[0], von[0], fs[0]} !==
                {1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL reset_state actual=%b%h%h%b%b%b%b%b%b", pe[0], hc[0], vc[0],
                         hsy[0], vsy[0], hb[0], vb[0], von[0], fs[0]);
            end
            tests_run++;
            if (pe[2] !== 1'b1) begin
                fails++;
                $display("FAIL reset_pix_en_div1 actual=%b expected=1", pe[2]);
            end
        end
        rst = 3'b000;
        tests_run++;
        if (pe[0] !== 1'b0) begin
            fails++;
            $display("FAIL release_cycle0_pix_en actual=%b expected=0", pe[0]);
        end
        @(negedge clk);
        tests_run++;
        if ({pe[0], fs[0]} !== 2'b11) begin
            fails++;
            $display("FAIL release_cycle1 pix_en/frame_start actual=%b%b expected=11", pe[0], fs[0]);
        end
        @(negedge clk);
        tests_run++;
        if (hc[0] !== 11'd1) begin
            fails++;
            $display("FAIL first_advance hcount actual=%0d expected=1", hc[0]);
        end
    endtask

    task automatic test_line_timing;
        int n, hs_clks, von_clks, pe_clks, hs_first, hs_last, v0;
        bit found;
        found = 0;
        for (n = 0; n < 1700 && !found; n++) begin
            @(negedge clk);
            found = (hc[0] == 11'd0) && pe[0];
        end
        tests_run++;
        if (!found) begin
            fails++;
            $display("FAIL line_start_timeout actual=none expected=hcount0");
            return;
        end
        v0 = vc[0];
        hs_clks = 0; von_clks = 0; pe_clks = 0; hs_first = -1; hs_last = -1;
        n = 0;
        do begin
            if (hsy[0] === 1'b0) begin
                hs_clks++;
                if (hs_first < 0) hs_first = hc[0];
                hs_last = hc[0];
            end
            if (von[0] === 1'b1) von_clks++;
            if (pe[0] === 1'b1) pe_clks++;
            @(negedge clk);
            n++;
        end while (!(hc[0] == 11'd0 && pe[0]) && n < 1700);
        tests_run++;
        if (n != 1600) begin fails++; $display("FAIL line_period actual=%0d expected=1600", n); end
        tests_run++;
        if (hs_clks != 192) begin fails++; $display("FAIL hs_width actual=%0d expected=192", hs_clks); end
        tests_run++;
        if (hs_first != 656 || hs_last != 751) begin
            fails++;
            $display("FAIL hs_window actual=%0d..%0d expected=656..751", hs_first, hs_last);
        end
        tests_run++;
        if (von_clks != 1280) begin fails++; $display("FAIL video_on_width actual=%0d expected=1280", von_clks); end
        tests_run++;
        if (pe_clks != 800) begin fails++; $display("FAIL pix_en_per_line actual=%0d expected=800", pe_clks); end
        tests_run++;
        if (vc[0] !== 11'(v0 + 1)) begin
            fails++;
            $display("FAIL vcount_step actual=%0d expected=%0d", vc[0], v0 + 1);
        end
    endtask

    task automatic test_frame;
        int n, vs_clks, vb_clks, fs_cnt, hmax, vmax;
        bit found;
        found = 0;
        for (n = 0; n < 1200 && !found; n++) begin
            @(negedge clk);
            found = fs[1];
        end
        tests_run++;
        if (!found) begin fails++; $display("FAIL frame_start_timeout actual=none expected=pulse"); return; end
        vs_clks = 0; vb_clks = 0; fs_cnt = 0; hmax = 0; vmax = 0; n = 0;
        do begin
            if (vsy[1] === 1'b0) vs_clks++;
            if (vb[1] === 1'b1) vb_clks++;
            if (hc[1] > hmax) hmax = hc[1];
            if (vc[1] > vmax) vmax = vc[1];
            @(negedge clk);
            n++;
            if (fs[1] === 1'b1) fs_cnt++;
        end while (!fs[1] && n < 1300);
        tests_run++;
        if (n != 1140) begin fails++; $display("FAIL frame_period actual=%0d expected=1140", n); end
        tests_run++;
        if (fs_cnt != 1) begin fails++; $display("FAIL frame_start_count actual=%0d expected=1", fs_cnt); end
        tests_run++;
        if (vs_clks != 120) begin fails++; $display("FAIL vs_width actual=%0d expected=120", vs_clks); end
        tests_run++;
        if (vb_clks != 420) begin fails++; $display("FAIL vblank_width actual=%0d expected=420", vb_clks); end
        tests_run++;
        if (hmax != 29 || vmax != 18) begin
            fails++;
            $display("FAIL count_max actual=%0d/%0d expected=29/18", hmax, vmax);
        end
    endtask

    task automatic test_wrap_corner;
        int n;
        bit found;
        found = 0;
        for (n = 0; n < 1200 && !found; n++) begin
            @(negedge clk);
            found = (hc[1] == 11'd29) && (vc[1] == 11'd18) && pe[1];
        end
        tests_run++;
        if (!found) begin fails++; $display("FAIL wrap_timeout actual=none expected=(29,18)"); return; end
        @(negedge clk);
        tests_run++;
        if ({hc[1], vc[1], vb[1], von[1], fs[1]} !== {11'd0, 11'd0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL wrap_state actual=%0d,%0d vb=%b von=%b fs=%b expected=0,0 vb=0 von=1 fs=0",
                     hc[1], vc[1], vb[1], von[1], fs[1]);
        end
        @(negedge clk);
        tests_run++;
        if ({pe[1], fs[1]} !== 2'b11) begin
            fails++;
            $display("FAIL wrap_frame_start actual=%b%b expected=11", pe[1], fs[1]);
        end
    endtask

    task automatic test_midframe_reset;
        int n;
        bit found;
        found = 0;
        for (n = 0; n < 1200 && !found; n++) begin
            @(negedge clk);
            found = (hc[1] == 11'd22) && (vc[1] == 11'd15);
        end
        tests_run++;
        if (!found) begin fails++; $display("FAIL midframe_timeout actual=none expected=(22,15)"); return; end
        tests_run++;
        if ({hsy[1], vsy[1]} !== 2'b00) begin
            fails++;
            $display("FAIL midframe_in_sync actual=hs%b vs%b expected=hs0 vs0", hsy[1], vsy[1]);
        end
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        tests_run++;
        if ({hc[1], vc[1], hsy[1], vsy[1], pe[1]} !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL midframe_reset actual=%0d,%0d hs=%b vs=%b pe=%b expected=0,0 hs=1 vs=1 pe=0",
                     hc[1], vc[1], hsy[1], vsy[1], pe[1]);
        end
        @(negedge clk);
        tests_run++;
        if ({pe[1], fs[1]} !== 2'b11) begin
            fails++;
            $display("FAIL midframe_resume actual=%b%b expected=11", pe[1], fs[1]);
        end
    endtask

    task automatic test_polarity;
        int n, hs_clks, vs_clks, pe_low;
        bit found;
        found = 0;
        for (n = 0; n < 600 && !found; n++) begin
            @(negedge clk);
            found = fs[2];
        end
        tests_run++;
        if (!found) begin fails++; $display("FAIL pol_frame_timeout actual=none expected=pulse"); return; end
        hs_clks = 0; vs_clks = 0; pe_low = 0; n = 0;
        do begin
            if (hsy[2] === 1'b1) hs_clks++;
            if (vsy[2] === 1'b1) vs_clks++;
            if (pe[2] !== 1'b1) pe_low++;
            @(negedge clk);
            n++;
        end while (!fs[2] && n < 700);
        tests_run++;
        if (n != 570) begin fails++; $display("FAIL pol_frame_period actual=%0d expected=570", n); end
        tests_run++;
        if (pe_low != 0) begin fails++; $display("FAIL pol_pix_en_low actual=%0d expected=0", pe_low); end
        tests_run++;
        if (hs_clks != 114) begin fails++; $display("FAIL pol_hs_high actual=%0d expected=114", hs_clks); end
        tests_run++;
        if (vs_clks != 60) begin fails++; $display("FAIL pol_vs_high actual=%0d expected=60", vs_clks); end
    endtask

    initial begin
        #(20 * 40000);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_line_timing();
        test_frame();
        test_wrap_corner();
        test_midframe_reset();
        test_polarity();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Raster timing generator for the VGA path; it sits directly upstream of the pixel/ball renderer and drives the VGA sync pins. It runs entirely on the 50 MHz board clock and produces a one-clock pixel enable strobe instead of a divided clock. From that strobe it maintains horizontal and vertical pixel counters and decodes sync, blanking, active-video and frame-start signals from them. The renderer consumes hcount/vcount/video_on/vblank/frame_start and advances its own logic only on pix_en.

Parameters:
CLK_DIV, 2, clk cycles per pixel (>=1); 50 MHz / 2 = 25 MHz pixel rate
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hs level while in sync (0 = active-low)
VS_POL, 0, vs level while in sync (0 = active-low)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high
pix_en  output  1  one-clk strobe, last clk of each pixel period
hcount  output  11  current pixel column, 0..H_TOTAL-1
vcount  output  11  current line, 0..V_TOTAL-1
hs  output  1  horizontal sync, polarity per HS_POL
vs  output  1  vertical sync, polarity per VS_POL
hblank  output  1  hcount >= H_VISIBLE
vblank  output  1  vcount >= V_VISIBLE
video_on  output  1  !hblank && !vblank
frame_start  output  1  one-clk pulse at pixel (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). Both must be <= 2047. Out-of-range values are a parameter error and need not be handled.
- Divider: register div counts 0..CLK_DIV-1 on every clk and wraps to 0. pix_en = (div == CLK_DIV-1). For CLK_DIV=1, pix_en is held constantly at 1.
- Counters update only on a clk edge where pix_en=1:
  - hcount = H_TOTAL-1 wraps to 0; otherwise it increments.
  - vcount increments only when hcount wraps. vcount = V_TOTAL-1 with hcount wrapping returns both counters to (0,0).
- Decodes are registered from next-state counter values, so hs/vs/hblank/vblank/video_on change on the same edge as hcount/vcount. There is zero cycles of skew between a count and its decode.
- Sync windows:
  - hs = HS_POL when hcount is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] ([656,751]); otherwise ~HS_POL.
  - vs = VS_POL when vcount is in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] ([490,491]); otherwise ~VS_POL.
  - vs transitions coincide with the hcount 799->0 wrap edge.
- frame_start = pix_en && hcount==0 && vcount==0, giving one clk per frame. The renderer updates object positions on this pulse instead of on a vblank edge.
- Reset (synchronous, overrides everything in the same edge):
  - div=0, hcount=0, vcount=0, hs=~HS_POL, vs=~VS_POL, hblank=0, vblank=0, video_on=1. pix_en and frame_start are therefore 0 while in reset (CLK_DIV>1).
  - Reset asserted mid-line or mid-frame aborts it immediately; no partial-frame completion.
- After reset release with CLK_DIV=2:
  - First pix_en is in release cycle 1, and frame_start pulses in the same cycle.
  - First counter advance (hcount 0->1) happens on the edge ending that cycle.
- Frame period is H_TOTAL*V_TOTAL*CLK_DIV clks (840000 at defaults, i.e. 59.52 Hz at 50 MHz).

Test Plan:
- Reset then run 2 lines -> pix_en every 2nd clk; hcount 0..799 then 0; vcount 0->1 on the same edge as the wrap; hblank rises at hcount=640, falls at 0.
- Line timing -> hs low for exactly 96 pixels (192 clks), from hcount=656 to 751; period 1600 clks; video_on high for 640 pixels per visible line.
- Full frame -> vs low on vcount 490..491 only (3200 clks); vblank high on vcount 480..524; frame_start pulses exactly once per 840000 clks at (0,0); hcount/vcount never exceed 799/524.
- Wrap corner -> at (799,524) with pix_en: the next edge gives (0,0), vblank=0, video_on=1, and frame_start in the following pix_en cycle.
- Assert rst for 1 clk at (700,491) -> next edge: hcount=0, vcount=0, vs=1, hs=1, div=0; timing resumes from (0,0).
- Instantiate with HS_POL=1, VS_POL=1, CLK_DIV=1 -> pix_en constantly 1, hs high for hcount 656..751, vs high for vcount 490..491, frame period 420000 clks.
